// File: rtl/mem_stage_pkg.sv
// Pipeline-wide types and widths shared by EX, MEM, WB and the forwarding unit.
package mem_stage_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int RAW    = 5;

  // Outstanding-access tracker states.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // EX/MEM pipeline register contents.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [RAW-1:0]    rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
  } ex_mem_t;

  // MEM/WB pipeline register contents.
  typedef struct packed {
    logic [DATA_W-1:0] wdata;
    logic [RAW-1:0]    rd;
    logic              reg_write;
  } mem_wb_t;

  // Word accesses only: the two low address bits must be zero.
  function automatic logic is_word_aligned(input logic [ADDR_W-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/mem_wait_ctrl.sv
// Tracks an outstanding data-memory access: counts wait states, aborts
// after MAX_WAIT of them, and decides when the front of the pipe stalls.
//
// Handshake: dmem_req is held with stable we/addr/wdata until a cycle in
// which dmem_ready=1 (that cycle completes the access, possibly the same
// cycle req first rises) or until the wait budget runs out, in which case
// req drops for one cycle and the instruction retires as a fault.
// dmem_ready is ignored whenever dmem_req=0.
module mem_wait_ctrl
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       access,      // aligned LW/SW sitting in EX/MEM
  input  logic       dmem_ready,
  output logic       dmem_req,
  output logic       mem_stall,
  output logic       timeout,
  output mem_state_t state
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  mem_state_t       state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_nxt;

  // The budget is exhausted only when the last allowed cycle also sees no ready.
  assign timeout   = (state == WAIT) && (wait_cnt == MAX_CNT) && !dmem_ready;
  assign dmem_req  = access && !timeout;
  assign mem_stall = dmem_req && !dmem_ready;

  // State register for the wait tracker.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Any non-stalled edge advances EX/MEM and so returns the tracker to IDLE;
  // each stalled edge adds one wait state.
  always_comb begin
    state_nxt    = IDLE;
    wait_cnt_nxt = '0;
    if (mem_stall) begin
      state_nxt    = WAIT;
      wait_cnt_nxt = (state == IDLE) ? ONE_CNT : wait_cnt + ONE_CNT;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: EX/MEM register, data-memory request, MEM/WB register,
// forwarding taps and the memory fault pulse.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  // from EX
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [RAW-1:0]    ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_mem_to_reg,
  // data memory
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  // hazard control
  output logic              mem_stall,
  // forwarding taps
  output logic [DATA_W-1:0] exmem_alu,
  output logic [RAW-1:0]    exmem_rd,
  output logic              exmem_reg_write,
  output logic [DATA_W-1:0] memwb_wdata,
  output logic [RAW-1:0]    memwb_rd,
  output logic              memwb_reg_write,
  // faults
  output logic              mem_exc,
  output logic [ADDR_W-1:0] mem_exc_addr,
  // observability
  output mem_state_t        dbg_state
);

  ex_mem_t m;
  mem_wb_t wb;

  logic mem_op;
  logic misaligned;
  logic access;
  logic timeout;
  logic fault;

  assign mem_op     = m.valid && (m.mem_read || m.mem_write);
  assign misaligned = mem_op && !is_word_aligned(ADDR_W'(m.alu_result));
  assign access     = mem_op && !misaligned;
  assign fault      = misaligned || timeout;

  mem_wait_ctrl #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait (
    .clk        (clk),
    .rst_n      (rst_n),
    .access     (access),
    .dmem_ready (dmem_ready),
    .dmem_req   (dmem_req),
    .mem_stall  (mem_stall),
    .timeout    (timeout),
    .state      (dbg_state)
  );

  // Request fields come straight from EX/MEM, so they hold while stalled.
  assign dmem_we    = m.mem_write;
  assign dmem_addr  = ADDR_W'(m.alu_result);
  assign dmem_wdata = m.store_data;

  // EX/MEM register: captures EX whenever the stage is not stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m <= '0;
    end else if (!mem_stall) begin
      m.valid      <= ex_valid;
      m.alu_result <= ex_alu_result;
      m.store_data <= ex_store_data;
      m.rd         <= ex_rd;
      m.reg_write  <= ex_reg_write;
      m.mem_read   <= ex_mem_read;
      m.mem_write  <= ex_mem_write;
      m.mem_to_reg <= ex_mem_to_reg;
    end
  end

  // MEM/WB register: a bubble per stall cycle, otherwise the retiring result.
  // Faulting instructions retire without writing the register file.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb <= '0;
    end else if (mem_stall) begin
      wb.reg_write <= 1'b0;
    end else begin
      wb.rd        <= m.rd;
      wb.reg_write <= m.valid && m.reg_write && !fault;
      wb.wdata     <= m.mem_to_reg ? dmem_rdata : m.alu_result;
    end
  end

  // Fault pulse: raised for one cycle as the faulting instruction retires.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_exc      <= 1'b0;
      mem_exc_addr <= '0;
    end else if (!mem_stall) begin
      mem_exc      <= fault;
      mem_exc_addr <= ADDR_W'(m.alu_result);
    end else begin
      mem_exc      <= 1'b0;
    end
  end

  assign memwb_wdata     = wb.wdata;
  assign memwb_rd        = wb.rd;
  assign memwb_reg_write = wb.reg_write;

  // Loads are never forwarded from EX/MEM; the load-use bubble covers them.
  assign exmem_alu       = m.alu_result;
  assign exmem_rd        = m.rd;
  assign exmem_reg_write = m.valid && m.reg_write && !m.mem_to_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: random instruction stream against a transaction-level
// model, a latency-programmable memory responder and a decoupled monitor.
`timescale 1ns/1ps
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int MAX_WAIT = 15;
  localparam int NEVER    = 40;
  localparam int EW       = 1 + RAW + DATA_W + 1 + ADDR_W;  // retire record
  localparam int RQW      = 1 + ADDR_W + DATA_W + 8;        // request record

  typedef struct {
    logic              valid;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] sdata;
    logic [RAW-1:0]    rd;
    logic              rw;
    logic              mr;
    logic              mw;
    logic              m2r;
    int                lat;
  } instr_t;

  // clock / reset block
  logic clk;
  logic rst_n;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic              ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [DATA_W-1:0] ex_alu_result, ex_store_data;
  logic [RAW-1:0]    ex_rd;
  logic              dmem_req, dmem_we, dmem_ready;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata, dmem_rdata;
  logic              mem_stall, exmem_reg_write, memwb_reg_write, mem_exc;
  logic [DATA_W-1:0] exmem_alu, memwb_wdata;
  logic [RAW-1:0]    exmem_rd, memwb_rd;
  logic [ADDR_W-1:0] mem_exc_addr;
  mem_state_t        dbg_state;

  mem_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .exmem_alu(exmem_alu), .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
    .memwb_wdata(memwb_wdata), .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
    .mem_exc(mem_exc), .mem_exc_addr(mem_exc_addr), .dbg_state(dbg_state)
  );

  // scoreboard state
  int errors = 0;
  int checks = 0;
  logic [EW-1:0]  exp_q[$];
  logic [RQW-1:0] req_q[$];
  int             stall_q[$];
  instr_t         mem_slot;
  logic [DATA_W-1:0] model_mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] resp_mem  [logic [ADDR_W-1:0]];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] default_word(input logic [ADDR_W-1:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [DATA_W-1:0] model_rd(input logic [ADDR_W-1:0] a);
    return model_mem.exists(a) ? model_mem[a] : default_word(a);
  endfunction

  function automatic logic [DATA_W-1:0] resp_rd(input logic [ADDR_W-1:0] a);
    return resp_mem.exists(a) ? resp_mem[a] : default_word(a);
  endfunction

  function automatic instr_t mk(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                                input logic [4:0] rd, input logic rw, input logic mr,
                                input logic mw, input logic m2r, input int lat);
    instr_t t;
    t.valid = v; t.alu = alu; t.sdata = sd; t.rd = rd;
    t.rw = rw; t.mr = mr; t.mw = mw; t.m2r = m2r; t.lat = lat;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    int k;
    int r;
    logic [31:0] addr;
    k = $urandom_range(0, 9);
    r = $urandom_range(0, 19);
    addr = 32'h100 + 32'($urandom_range(0, 15) * 4);
    if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
    t = mk(1'b1, $urandom, $urandom, 5'($urandom_range(1, 31)), 1'b1, 1'b0, 1'b0, 1'b0, 0);
    if (r < 12)       t.lat = r % 4;
    else if (r < 16)  t.lat = r - 8;
    else if (r == 16) t.lat = 14;
    else if (r == 17) t.lat = 15;
    else if (r == 18) t.lat = 16;
    else              t.lat = NEVER;
    case (k)
      0: begin t.valid = 1'b0; t.rw = 1'($urandom); t.mr = 1'($urandom); t.mw = 1'($urandom); end
      4, 5, 6: begin t.alu = addr; t.mr = 1'b1; t.m2r = 1'b1; end
      7, 8: begin t.alu = addr; t.mw = 1'b1; t.rw = 1'b0; end
      9: t.rw = 1'b0;
      default: ;
    endcase
    return t;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    model_mem[a] = d;
    resp_mem[a]  = d;
  endtask

  // driver: called just after a rising edge; returns just after the capture edge
  task automatic issue(input instr_t t);
    logic s;
    int guard;
    logic memop, mis, to, fault, rwx;
    logic [DATA_W-1:0] wd;
    int st;
    ex_valid = t.valid; ex_alu_result = t.alu; ex_store_data = t.sdata; ex_rd = t.rd;
    ex_reg_write = t.rw; ex_mem_read = t.mr; ex_mem_write = t.mw; ex_mem_to_reg = t.m2r;
    guard = 0;
    forever begin
      @(negedge clk);
      s = mem_stall;
      @(posedge clk);
      if (!s) break;
      guard++;
      if (guard > 4 * MAX_WAIT) begin
        checks++; errors++;
        $display("FAIL capture_timeout: stall held %0d cycles, limit %0d", guard, 4 * MAX_WAIT);
        break;
      end
    end
    #1;
    // reference model: one instruction, whole outcome
    memop = t.valid && (t.mr || t.mw);
    mis   = memop && (t.alu[1:0] != 2'b00);
    to    = memop && !mis && (t.lat > MAX_WAIT);
    fault = mis || to;
    rwx   = t.valid && t.rw && !fault;
    wd    = t.m2r ? model_rd(t.alu) : t.alu;
    if (memop && t.mw && !fault) model_mem[t.alu] = t.sdata;
    exp_q.push_back({rwx, t.rd, wd, fault, t.alu});
    if (memop && !mis) begin
      req_q.push_back({t.mw, t.alu, (t.mw ? t.sdata : 32'h0), 8'(t.lat)});
      st = (t.lat > MAX_WAIT) ? MAX_WAIT : t.lat;
      if (st > 0) stall_q.push_back(st);
    end
    mem_slot = t;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dmem_req"}, dmem_req, 0);
    check({tag, "_mem_stall"}, mem_stall, 0);
    check({tag, "_memwb_reg_write"}, memwb_reg_write, 0);
    check({tag, "_memwb_rd"}, memwb_rd, 0);
    check({tag, "_memwb_wdata"}, memwb_wdata, 0);
    check({tag, "_mem_exc"}, mem_exc, 0);
    check({tag, "_mem_exc_addr"}, mem_exc_addr, 0);
    check({tag, "_exmem_alu"}, exmem_alu, 0);
    check({tag, "_exmem_reg_write"}, exmem_reg_write, 0);
    check({tag, "_state"}, dbg_state, IDLE);
  endtask

  task automatic release_reset();
    exp_q.delete();
    req_q.delete();
    stall_q.delete();
    exp_q.push_back('0);
    mem_slot = mk(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  // memory responder: ready after a per-access latency, idle noise on ready
  initial begin
    int busy;
    int lat;
    logic pend, comp, c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [RQW-1:0] r;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    busy = 0;
    lat = 0;
    forever begin
      @(negedge clk);
      pend = dmem_req && !dmem_ready;
      comp = dmem_req && dmem_ready;
      c_we = dmem_we; c_addr = dmem_addr; c_wdata = dmem_wdata;
      @(posedge clk);
      if (!rst_n) busy = 0;
      else begin
        if (comp && c_we) resp_mem[c_addr] = c_wdata;
        busy = pend ? busy + 1 : 0;
      end
      #1;
      if (busy == 0 && dmem_req) begin
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_request: addr %0h we %0b, no request expected", dmem_addr, dmem_we);
          lat = 0;
        end else begin
          r = req_q.pop_front();
          check("req_we", dmem_we, r[72]);
          check("req_addr", dmem_addr, r[71:40]);
          if (r[72]) check("req_wdata", dmem_wdata, r[39:8]);
          lat = int'(r[7:0]);
        end
        dmem_ready = (lat == 0);
      end else if (busy == 0) begin
        dmem_ready = 1'($urandom);
      end else begin
        dmem_ready = (busy == lat);
      end
      dmem_rdata = dmem_ready ? resp_rd(dmem_addr) : $urandom;
    end
  end

  // monitor: forwarding taps, stall lengths, request stability, retirements
  initial begin
    logic adv, pstall, p_we;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic [EW-1:0] e;
    int run;
    run = 0; pstall = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
    forever begin
      @(negedge clk);
      adv = rst_n && !mem_stall;
      if (!rst_n) begin
        run = 0;
      end else begin
        check("exmem_alu", exmem_alu, mem_slot.alu);
        check("exmem_rd", exmem_rd, mem_slot.rd);
        check("exmem_reg_write", exmem_reg_write, mem_slot.valid && mem_slot.rw && !mem_slot.m2r);
        if (pstall) begin
          check("stable_we", dmem_we, p_we);
          check("stable_addr", dmem_addr, p_addr);
          check("stable_wdata", dmem_wdata, p_wdata);
        end
        if (mem_stall) run++;
        else if (run > 0) begin
          if (stall_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL stall_len: stall of %0d cycles, none expected", run);
          end else check("stall_len", run, stall_q.pop_front());
          run = 0;
        end
      end
      pstall = rst_n && mem_stall;
      p_we = dmem_we; p_addr = dmem_addr; p_wdata = dmem_wdata;
      @(posedge clk);
      #1;
      if (adv) begin
        check("state_idle_on_advance", dbg_state, IDLE);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL retire_empty: retirement with no expected entry");
        end else begin
          e = exp_q.pop_front();
          check("memwb_reg_write", memwb_reg_write, e[70]);
          if (e[70]) begin
            check("memwb_rd", memwb_rd, e[69:65]);
            check("memwb_wdata", memwb_wdata, e[64:33]);
          end
          check("mem_exc", mem_exc, e[32]);
          if (e[32]) check("mem_exc_addr", mem_exc_addr, e[31:0]);
        end
      end else begin
        check("bubble_reg_write", memwb_reg_write, 0);
        check("bubble_mem_exc", mem_exc, 0);
      end
    end
  end

  // watchdog
  initial begin
    #500us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    rst_n = 1'b0;
    ex_valid = 0; ex_alu_result = 0; ex_store_data = 0; ex_rd = 0;
    ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0;
    mem_slot = mk(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    release_reset();

    preload(32'h100, 32'hDEAD_BEEF);
    issue(mk(1, 32'h30, 0, 5, 1, 0, 0, 0, 0));                 // ALU add
    issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    issue(mk(1, 32'h100, 0, 6, 1, 1, 0, 1, 0));                // LW zero-wait
    issue(mk(1, 32'h104, 32'h1234, 0, 0, 0, 1, 0, 3));         // SW 3 waits
    issue(mk(1, 32'h77, 0, 9, 1, 0, 0, 0, 0));                 // held during stall
    issue(mk(1, 32'h102, 0, 7, 1, 1, 0, 1, 0));                // misaligned LW
    issue(mk(1, 32'h200, 0, 8, 1, 1, 0, 1, NEVER));            // timeout
    issue(mk(1, 32'h104, 0, 10, 1, 1, 0, 1, 1));               // reads back store
    issue(mk(1, 32'h108, 0, 11, 1, 1, 0, 1, 15));              // ready on last cycle
    issue(mk(1, 32'h10C, 0, 12, 1, 1, 0, 1, 16));              // one cycle too late
    issue(mk(1, 32'h110, 32'h55, 0, 0, 0, 1, 0, NEVER));       // timed-out store
    issue(mk(1, 32'h110, 0, 13, 1, 1, 0, 1, 0));               // store must not land

    for (int i = 0; i < 300; i++) issue(rand_instr());

    // reset during the second wait cycle of a load
    issue(mk(1, 32'h200, 0, 14, 1, 1, 0, 1, NEVER));
    ex_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    release_reset();
    issue(mk(1, 32'h44, 0, 3, 1, 0, 0, 0, 0));
    issue(mk(1, 32'h10C, 0, 4, 1, 1, 0, 1, 2));
    issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    @(posedge clk);
    #2;
    check("drain_exp_q", exp_q.size(), 0);
    check("drain_req_q", req_q.size(), 0);
    check("drain_stall_q", stall_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
